// File: rtl/deglitch_pkg.sv
// Shared constants, per-channel state record and effective-threshold helper
// for the multi-channel deglitch filter.
package deglitch_pkg;

    localparam int unsigned CH_DEF     = 8;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned CNT_MAX_W  = 32;

    // cnt is held at the widest legal CNT_W; it never exceeds eff-1, so the
    // bits above the configured CNT_W stay zero and fold away in synthesis.
    typedef struct packed {
        logic                 s1;
        logic                 s2;
        logic [CNT_MAX_W-1:0] cnt;
        logic                 host_f;
    } ch_state_t;

    function automatic logic [CNT_MAX_W-1:0] eff_f(input logic [CNT_MAX_W-1:0] t);
        return (t == '0) ? 32'd1 : t;
    endfunction

endpackage

// File: rtl/multi_deglitch_if.sv
// Channel bundle of the deglitch filter: raw inputs and threshold in,
// filtered levels and edge pulses out.
interface multi_deglitch_if
    import deglitch_pkg::*;
#(
    parameter int unsigned CH    = CH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic [CH-1:0]    host;
    logic [CNT_W-1:0] thresh;
    logic [CH-1:0]    host_f;
    logic [CH-1:0]    rise;
    logic [CH-1:0]    fall;

    modport master (output host, output thresh, input host_f, input rise, input fall);
    modport slave  (input host, input thresh, output host_f, output rise, output fall);
endinterface

// File: rtl/deglitch_ch.sv
// One deglitch channel: two-flop synchroniser, saturating stability counter
// and optional edge flops (MULTI_DEGLITCH_EDGE_EN).
module deglitch_ch
    import deglitch_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_i,
    input  logic [CNT_MAX_W-1:0] eff_i,
    output logic                 host_f_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    ch_state_t st_q, st_d;

    always_comb begin
        st_d    = st_q;
        st_d.s1 = host_i;
        st_d.s2 = st_q.s1;
        if (st_q.s2 == st_q.host_f) begin
            st_d.cnt = '0;
        end else if (st_q.cnt + 32'd1 >= eff_i) begin
            // Compare with >= so a threshold lowered below cnt flips at once.
            st_d.host_f = st_q.s2;
            st_d.cnt    = '0;
        end else begin
            st_d.cnt = st_q.cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q.s1     <= RST_BIT;
            st_q.s2     <= RST_BIT;
            st_q.cnt    <= '0;
            st_q.host_f <= RST_BIT;
        end else begin
            st_q <= st_d;
        end
    end

    assign host_f_o = st_q.host_f;

`ifdef MULTI_DEGLITCH_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= st_d.host_f & ~st_q.host_f;
            fall_q <= ~st_d.host_f & st_q.host_f;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/multi_deglitch.sv
// Multi-channel input deglitcher: CH independent deglitch_ch instances sharing
// one runtime threshold. Edge pulses built only with MULTI_DEGLITCH_EDGE_EN.
module multi_deglitch
    import deglitch_pkg::*;
#(
    parameter int unsigned   CH      = CH_DEF,
    parameter int unsigned   CNT_W   = CNT_W_DEF,
    parameter logic [CH-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    multi_deglitch_if.slave bus
);

    logic [CNT_MAX_W-1:0] eff;
    logic [CH-1:0]        hf, rs, fl;

    assign eff = eff_f(32'(bus.thresh));

    for (genvar g = 0; g < CH; g++) begin : g_ch
        deglitch_ch #(
            .RST_BIT (RST_VAL[g])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .host_i   (bus.host[g]),
            .eff_i    (eff),
            .host_f_o (hf[g]),
            .rise_o   (rs[g]),
            .fall_o   (fl[g])
        );
    end

    assign bus.host_f = hf;
    assign bus.rise   = rs;
    assign bus.fall   = fl;

endmodule

// File: tb/tb_multi_deglitch.sv
// Directed bench for multi_deglitch (CH=4, CNT_W=8, RST_VAL=0, 20 ns clock);
// edge-pulse expectations follow MULTI_DEGLITCH_EDGE_EN.
module tb_multi_deglitch;

`ifdef MULTI_DEGLITCH_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    multi_deglitch_if #(.CH(4), .CNT_W(8)) bus ();

    multi_deglitch #(
        .CH      (4),
        .CNT_W   (8),
        .RST_VAL (4'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check n edges; host_f switches b->a at edge `flip`, pulses rm/fm there.
    task automatic watch(input string tag, input int n, input int flip,
                         input logic [3:0] b, input logic [3:0] a,
                         input logic [3:0] rm, input logic [3:0] fm);
        for (int e = 1; e <= n; e++) begin
            tick();
            chk($sformatf("%s_hf_e%0d", tag, e), 32'(bus.host_f), 32'((e >= flip) ? a : b));
            chk($sformatf("%s_rise_e%0d", tag, e), 32'(bus.rise),
                32'((e == flip && EDGE) ? rm : 4'h0));
            chk($sformatf("%s_fall_e%0d", tag, e), 32'(bus.fall),
                32'((e == flip && EDGE) ? fm : 4'h0));
        end
    endtask

    initial begin
        bus.host   = 4'h0;
        bus.thresh = 8'd4;
        rst        = 1'b1;
        tick();
        tick();
        chk("rst_hf", 32'(bus.host_f), 32'h0);
        chk("rst_rise", 32'(bus.rise), 32'h0);
        chk("rst_fall", 32'(bus.fall), 32'h0);
        rst = 1'b0;
        tick();

        // Single-channel step, thresh=4: flips at edge 6.
        bus.host = 4'h1;
        watch("step_up", 7, 6, 4'h0, 4'h1, 4'h1, 4'h0);
        bus.host = 4'h0;
        watch("step_dn", 7, 6, 4'h1, 4'h0, 4'h0, 4'h1);

        // 50 ns glitch on channel 1 is discarded.
        bus.host = 4'h2;
        #50;
        bus.host = 4'h0;
        watch("glitch", 8, 99, 4'h0, 4'h0, 4'h0, 4'h0);

        // thresh=0 behaves as thresh=1: flip at edge 3.
        bus.thresh = 8'd0;
        bus.host   = 4'h4;
        watch("t0_up", 5, 3, 4'h0, 4'h4, 4'h4, 4'h0);
        bus.host = 4'h0;
        watch("t0_dn", 5, 3, 4'h4, 4'h0, 4'h0, 4'h4);
        bus.thresh = 8'd1;
        bus.host   = 4'h4;
        watch("t1_up", 5, 3, 4'h0, 4'h4, 4'h4, 4'h0);
        bus.host = 4'h0;
        watch("t1_dn", 5, 3, 4'h4, 4'h0, 4'h0, 4'h4);

        // All channels together, thresh=3: flip at edge 5.
        bus.thresh = 8'd3;
        bus.host   = 4'hF;
        watch("all_up", 6, 5, 4'h0, 4'hF, 4'hF, 4'h0);
        bus.host = 4'h0;
        watch("all_dn", 6, 5, 4'hF, 4'h0, 4'h0, 4'hF);

        // Reset mid-count (cnt=2 after 4 edges), then restart.
        bus.thresh = 8'd4;
        bus.host   = 4'h1;
        watch("pre_rst", 4, 99, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        tick();
        chk("midrst_hf", 32'(bus.host_f), 32'h0);
        chk("midrst_rise", 32'(bus.rise), 32'h0);
        chk("midrst_fall", 32'(bus.fall), 32'h0);
        rst = 1'b0;
        watch("post_rst", 7, 6, 4'h0, 4'h1, 4'h1, 4'h0);

        // Threshold lowered below a running count flips on the next edge.
        bus.thresh = 8'd8;
        bus.host   = 4'h0;
        watch("lower_hold", 6, 99, 4'h1, 4'h1, 4'h0, 4'h0);
        bus.thresh = 8'd2;
        watch("lower_flip", 2, 1, 4'h1, 4'h0, 4'h0, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_deglitch.md
MULTI_DEGLITCH -- requirements
Module: multi_deglitch

Interface
REQ-001 SHALL have parameter CH, default 8, number of independent input channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the per-channel stability counter and of thresh.
REQ-003 SHALL have parameter RST_VAL, default '0 (CH bits), per-channel reset value of host_f and of the synchroniser flops.
REQ-004 SHALL have port: clk  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: host  input  CH  asynchronous raw inputs, one per channel.
REQ-007 SHALL have port: thresh  input  CNT_W  runtime filter length in cycles, shared by all channels, quasi-static.
REQ-008 SHALL have port: host_f  output  CH  filtered, synchronised channel levels.
REQ-009 SHALL have port: rise  output  CH  one-cycle pulse per channel on a filtered 0->1 change.
REQ-010 SHALL have port: fall  output  CH  one-cycle pulse per channel on a filtered 1->0 change.

Function
REQ-011 SHALL pass each host bit through a two-flop synchroniser (s1, s2) before any filtering.
REQ-012 SHALL use effective threshold eff = max(thresh, 1); thresh = 0 behaves as thresh = 1.
REQ-013 SHALL, per channel on each clk edge: if s2 == host_f, clear cnt; else if cnt+1 >= eff, load host_f <= s2 and clear cnt; else increment cnt.
REQ-014 SHALL change host_f on rising edge N+2 after the host change, edge 1 being the first edge that samples the new level (N = eff), provided host stays stable.
REQ-015 SHALL discard a glitch: any return of s2 to host_f before the threshold is reached clears cnt, and host_f does not change.
REQ-016 SHALL never wrap cnt; cnt stays <= eff-1 at all times.
REQ-017 SHALL, when thresh is lowered below a channel's current cnt, flip that channel on the next edge at which s2 != host_f.
REQ-018 SHALL assert rise[i] (fall[i]) high for exactly the one cycle after host_f[i] goes 0->1 (1->0), registered alongside host_f.
REQ-019 SHALL keep channels fully independent; simultaneous flips on several channels are all honoured in the same cycle.

Reset
REQ-020 SHALL, while rst is high at a clk edge, load s1, s2 and host_f with RST_VAL, clear every cnt, and drive rise = fall = 0.
REQ-021 SHALL abandon any count in progress when rst is asserted mid-count; filtering restarts from RST_VAL after rst falls.

Configuration
REQ-022 SHALL, with macro MULTI_DEGLITCH_EDGE_EN defined, implement rise/fall per REQ-018.
REQ-023 SHALL, without MULTI_DEGLITCH_EDGE_EN, keep the rise/fall ports, tie them to 0, and synthesise no edge flops.

Structure
REQ-024 SHALL place in package deglitch_pkg: default CH/CNT_W constants, the per-channel state typedef (s1, s2, cnt, host_f), and the function computing eff.
REQ-025 SHALL implement one channel in sub-module deglitch_ch (synchroniser, counter, edge flop), instantiated CH times via generate.

Verification (clk period 20 ns, CH=4, CNT_W=8, RST_VAL=0)
REQ-026 SHALL cover: thresh=4, host[0] 0->1 held -> host_f[0]=1 at edge 6, rise[0] high for one cycle, other channels 0.
REQ-027 SHALL cover: thresh=4, host[1] high-pulse 50 ns (< 3 stable cycles) -> host_f[1] stays 0, no rise/fall.
REQ-028 SHALL cover: thresh=0 vs thresh=1, same step on host[2] -> identical host_f timing (edge 3).
REQ-029 SHALL cover: all four host bits toggle together, thresh=3 -> host_f = 4'hF in the same cycle, rise = 4'hF for one cycle.
REQ-030 SHALL cover: rst high at an edge while cnt[0]=2 -> host_f=0, cnt=0, rise=fall=0; with host[0] still high, host_f[0]=1 at edge eff+2 counted from the first edge after rst falls.
REQ-031 SHALL cover: build without MULTI_DEGLITCH_EDGE_EN -> rise = fall = 0 throughout REQ-026 stimulus, host_f unchanged.
